// File: rtl/ee354_gcd_param.sv
// ee354_gcd_param: binary (Stein) GCD engine with single-step support.
// SUB and MULT work only when SCEN is high, so the board can walk through
// the computation one step at a time. State is one-hot and mirrored on q_*.
module ee354_gcd_param #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 16
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         SCEN,
    input  logic                         Start,
    input  logic                         Ack,
    input  logic [WIDTH-1:0]             Ain,
    input  logic [WIDTH-1:0]             Bin,
    output logic [WIDTH-1:0]             A,
    output logic [WIDTH-1:0]             B,
    output logic [WIDTH-1:0]             AB_GCD,
    output logic [$clog2(WIDTH+1)-1:0]   i_count,
    output logic [CYC_W-1:0]             Cycles,
    output logic                         Zero_Err,
    output logic                         q_I,
    output logic                         q_Chk,
    output logic                         q_Sub,
    output logic                         q_Mult,
    output logic                         q_Done
);

    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [4:0] {
        INI  = 5'b00001,
        CHK  = 5'b00010,
        SUB  = 5'b00100,
        MULT = 5'b01000,
        DONE = 5'b10000
    } state_t;

    state_t state, state_next;

    logic [CYC_W-1:0] cycles_inc;
    logic             a_zero, b_zero;

    assign a_zero     = (A == '0);
    assign b_zero     = (B == '0);
    assign cycles_inc = (Cycles == '1) ? Cycles : Cycles + 1'b1;

    assign q_I    = (state == INI);
    assign q_Chk  = (state == CHK);
    assign q_Sub  = (state == SUB);
    assign q_Mult = (state == MULT);
    assign q_Done = (state == DONE);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= INI;
        else       state <= state_next;
    end

    // Next-state logic; any non one-hot encoding falls back to INI.
    always_comb begin
        state_next = state;
        case (state)
            INI:  if (Start) state_next = CHK;
            CHK:  state_next = (a_zero || b_zero) ? DONE : SUB;
            SUB:  if (SCEN && (A == B))
                      state_next = (i_count != '0) ? MULT : DONE;
            MULT: if (SCEN && (i_count == CW'(1))) state_next = DONE;
            DONE: if (Ack) state_next = INI;
            default: state_next = INI;
        endcase
    end

    // Datapath: operand capture, Stein reduction and power-of-two restore.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            A        <= '0;
            B        <= '0;
            AB_GCD   <= '0;
            i_count  <= '0;
            Cycles   <= '0;
            Zero_Err <= 1'b0;
        end else begin
            case (state)
                INI: begin
                    A        <= Ain;
                    B        <= Bin;
                    AB_GCD   <= '0;
                    i_count  <= '0;
                    Cycles   <= '0;
                    Zero_Err <= 1'b0;
                end
                CHK: begin
                    if (a_zero && b_zero) begin
                        AB_GCD   <= '0;
                        Zero_Err <= 1'b1;
                    end else if (a_zero) begin
                        AB_GCD <= B;
                    end else if (b_zero) begin
                        AB_GCD <= A;
                    end
                end
                SUB: begin
                    if (SCEN) begin
                        Cycles <= cycles_inc;
                        if (A == B) begin
                            AB_GCD <= A;
                        end else if (A < B) begin
                            A <= B;
                            B <= A;
                        end else if (A[0] && B[0]) begin
                            A <= A - B;
                        end else if (!A[0] && !B[0]) begin
                            A       <= A >> 1;
                            B       <= B >> 1;
                            i_count <= i_count + 1'b1;
                        end else if (!A[0]) begin
                            A <= A >> 1;
                        end else begin
                            B <= B >> 1;
                        end
                    end
                end
                MULT: begin
                    if (SCEN) begin
                        AB_GCD  <= AB_GCD << 1;
                        i_count <= i_count - 1'b1;
                        Cycles  <= cycles_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ee354_gcd_param.sv
// Self-checking bench for ee354_gcd_param at WIDTH=8 and WIDTH=16.
module tb_ee354_gcd_param;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        SCEN = 1'b0;
    logic        Start = 1'b0;
    logic        Ack = 1'b0;
    logic [15:0] ain = '0;
    logic [15:0] bin = '0;
    logic        sel16 = 1'b0;

    logic [7:0]  a8, b8, g8;
    logic [3:0]  i8;
    logic [15:0] c8;
    logic        z8, qi8, qc8, qs8, qm8, qd8;
    logic [15:0] a16, b16, g16;
    logic [4:0]  i16;
    logic [15:0] c16;
    logic        z16, qi16, qc16, qs16, qm16, qd16;

    logic [15:0] oA, oB, oG, oC;
    logic [4:0]  oI, oQ;
    logic        oZ;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 Clk = ~Clk;

    ee354_gcd_param #(.WIDTH(8), .CYC_W(16)) dut8 (
        .Clk(Clk), .Reset(Reset), .SCEN(SCEN), .Start(Start), .Ack(Ack),
        .Ain(ain[7:0]), .Bin(bin[7:0]), .A(a8), .B(b8), .AB_GCD(g8),
        .i_count(i8), .Cycles(c8), .Zero_Err(z8),
        .q_I(qi8), .q_Chk(qc8), .q_Sub(qs8), .q_Mult(qm8), .q_Done(qd8)
    );

    ee354_gcd_param #(.WIDTH(16), .CYC_W(16)) dut16 (
        .Clk(Clk), .Reset(Reset), .SCEN(SCEN), .Start(Start), .Ack(Ack),
        .Ain(ain), .Bin(bin), .A(a16), .B(b16), .AB_GCD(g16),
        .i_count(i16), .Cycles(c16), .Zero_Err(z16),
        .q_I(qi16), .q_Chk(qc16), .q_Sub(qs16), .q_Mult(qm16), .q_Done(qd16)
    );

    // Present the selected instance through one set of observation signals.
    always_comb begin
        if (sel16) begin
            oA = a16; oB = b16; oG = g16; oI = i16; oC = c16; oZ = z16;
            oQ = {qd16, qm16, qs16, qc16, qi16};
        end else begin
            oA = {8'h00, a8}; oB = {8'h00, b8}; oG = {8'h00, g8};
            oI = {1'b0, i8}; oC = c8; oZ = z8;
            oQ = {qd8, qm8, qs8, qc8, qi8};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference GCD by Euclid's remainder method.
    function automatic int unsigned euclid(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Step count and peak factor-of-two count implied by the Stein rules.
    function automatic void stein_steps(input int unsigned a, input int unsigned b,
                                        output int unsigned cyc, output int unsigned peak);
        int unsigned k, t;
        cyc = 0; peak = 0; k = 0;
        if (a == 0 || b == 0) return;
        forever begin
            cyc++;
            if (a == b) break;
            if (a < b) begin
                t = a; a = b; b = t;
            end else if ((a % 2 == 1) && (b % 2 == 1)) begin
                a = a - b;
            end else if ((a % 2 == 0) && (b % 2 == 0)) begin
                a = a / 2; b = b / 2; k++;
                if (k > peak) peak = k;
            end else if (a % 2 == 0) begin
                a = a / 2;
            end else begin
                b = b / 2;
            end
        end
        cyc += k;
    endfunction

    // One full run: load, start, step with SCEN every 'period' clocks, check, acknowledge.
    task automatic run(input bit w16, input int unsigned a, input int unsigned b,
                       input int unsigned period);
        int unsigned exp_cyc, exp_peak, peak, n;
        logic [15:0] pa, pb, pc;
        logic [4:0]  pi;
        bit          work;
        stein_steps(a, b, exp_cyc, exp_peak);
        @(negedge Clk);
        sel16 = w16; ain = 16'(a); bin = 16'(b); Start = 1'b1; SCEN = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        check("enter_chk", {63'd0, oQ[1]}, 64'd1);
        peak = 0;
        for (n = 0; n < 4000; n++) begin
            if (oQ[4]) break;
            check("onehot", {63'd0, $onehot(oQ)}, 64'd1);
            if (oI > peak) peak = oI;
            pa = oA; pb = oB; pc = oC; pi = oI;
            work = oQ[2] | oQ[3];
            SCEN = ((n % period) == period - 1);
            @(negedge Clk);
            if (work && !SCEN)
                check("frozen", {11'd0, pi, pc, pa, pb}, {11'd0, oI, oC, oA, oB});
        end
        check("timeout", {63'd0, oQ[4]}, 64'd1);
        check("gcd", 64'(oG), 64'(euclid(a, b)));
        check("cycles", 64'(oC), 64'(exp_cyc));
        check("zero_err", {63'd0, oZ}, {63'd0, (a == 0 && b == 0)});
        check("i_end", 64'(oI), 64'd0);
        check("i_peak", 64'(peak), 64'(exp_peak));
        @(negedge Clk);
        check("done_hold", {48'd0, oG}, 64'(euclid(a, b)));
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        check("ack_ini", {59'd0, oQ}, 64'd1);
        @(negedge Clk);
        check("ini_clear", {47'd0, oZ, oC}, 64'd0);
    endtask

    initial begin
        int unsigned runs, n, ra, rb, exp_cyc, exp_peak;

        // Reset state on both instances.
        repeat (2) @(negedge Clk);
        for (int s = 0; s < 2; s++) begin
            sel16 = 1'(s);
            #1;
            check("rst_regs", {oA, oB, oG, oC}, 64'd0);
            check("rst_misc", {58'd0, oI, oZ}, 64'd0);
            check("rst_state", {59'd0, oQ}, 64'd1);
        end
        @(negedge Clk);
        Reset = 1'b0;

        // Directed cases.
        run(1'b0, 36, 24, 1);
        run(1'b0, 0, 9, 1);
        run(1'b0, 9, 0, 1);
        run(1'b0, 0, 0, 1);
        run(1'b0, 255, 255, 4);
        run(1'b0, 1, 128, 3);
        run(1'b1, 48000, 36000, 1);
        run(1'b1, 65535, 1, 2);

        // Randomised operands with varying step rates.
        for (int k = 0; k < 12; k++) begin
            ra = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
            rb = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 255);
            run(1'b0, ra, rb, $urandom_range(1, 3));
        end
        for (int k = 0; k < 6; k++) begin
            ra = $urandom_range(1, 65535) << $urandom_range(0, 4);
            rb = $urandom_range(1, 65535) << $urandom_range(0, 4);
            run(1'b1, ra & 16'hffff, rb & 16'hffff, $urandom_range(1, 2));
        end

        // Reset asserted while restoring factors of two.
        @(negedge Clk);
        sel16 = 1'b1; ain = 16'd48000; bin = 16'd36000; Start = 1'b1; SCEN = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (n = 0; n < 200 && !oQ[3]; n++) @(negedge Clk);
        check("reach_mult", {63'd0, oQ[3]}, 64'd1);
        #2 Reset = 1'b1;
        #1;
        check("midrst_regs", {oA, oB, oG, oC}, 64'd0);
        check("midrst_misc", {58'd0, oI, oZ}, 64'd0);
        check("midrst_state", {59'd0, oQ}, 64'd1);
        @(negedge Clk);
        Reset = 1'b0;

        // Start and Ack both held: back-to-back runs.
        stein_steps(12, 18, exp_cyc, exp_peak);
        sel16 = 1'b0; ain = 16'd12; bin = 16'd18; SCEN = 1'b1;
        Start = 1'b1; Ack = 1'b1;
        runs = 0;
        for (n = 0; n < 300 && runs < 3; n++) begin
            @(negedge Clk);
            if (oQ[1]) check("b2b_chk_cycles", 64'(oC), 64'd0);
            if (oQ[4]) begin
                check("b2b_gcd", 64'(oG), 64'd6);
                check("b2b_cycles", 64'(oC), 64'(exp_cyc));
                runs++;
            end
        end
        check("b2b_runs", 64'(runs), 64'd3);
        Start = 1'b0;
        @(negedge Clk);
        Ack = 1'b0;
        check("b2b_end_ini", {59'd0, oQ}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
